// File: rtl/dm_cache_pkg.sv
// rtl/dm_cache_pkg.sv - shared defaults, derived geometry and FSM state type for the direct-mapped cache
package dm_cache_pkg;

    localparam int DM_ADDR_W  = 11;
    localparam int DM_DATA_W  = 8;
    localparam int DM_INDEX_W = 4;
    localparam int DM_TAG_W   = DM_ADDR_W - DM_INDEX_W;
    localparam int DM_LINES   = 1 << DM_INDEX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_RESP
    } state_t;

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// rtl/dm_cache_array.sv - valid/tag/data line storage, combinational read, single write port
module dm_cache_array
    import dm_cache_pkg::*;
#(
    parameter int INDEX_W = DM_INDEX_W,
    parameter int TAG_W   = DM_TAG_W,
    parameter int DATA_W  = DM_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_all,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // Valid bits: the only storage that needs reset; flush clears them all at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written only through the single write port, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through cache controller (optional stats: DM_CACHE_STATS_EN)
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W  = DM_ADDR_W,
    parameter int DATA_W  = DM_DATA_W,
    parameter int INDEX_W = DM_INDEX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t state, state_nx;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;

    logic              hit;
    logic              accept;
    logic              arr_clr;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;

    // Flush wins over a pending request, so the CPU sees not-ready on a flush cycle.
    assign cpu_ready = (state == ST_IDLE) && !flush;
    assign accept    = cpu_ready && cpu_req;
    assign hit       = line_valid && (line_tag == req_addr[ADDR_W-1:INDEX_W]);

    // Status and memory handshake decode straight from the state so reset drops them immediately.
    assign cpu_done  = (state == ST_RESP);
    assign mem_req   = (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign mem_we    = (state == ST_MEM_WR);

    dm_cache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (arr_clr),
        .rd_idx   (req_addr[INDEX_W-1:0]),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_idx   (req_addr[INDEX_W-1:0]),
        .wr_tag   (req_addr[ADDR_W-1:INDEX_W]),
        .wr_data  (arr_wdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic plus array write/clear strobes.
    always_comb begin
        state_nx  = state;
        arr_clr   = 1'b0;
        arr_we    = 1'b0;
        arr_wdata = req_wdata;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    arr_clr = 1'b1;
                end else if (cpu_req) begin
                    state_nx = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (req_we) begin
                    // Write-through, no-write-allocate: only a hit touches the line.
                    arr_we   = hit;
                    state_nx = ST_MEM_WR;
                end else if (hit) begin
                    state_nx = ST_RESP;
                end else begin
                    state_nx = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem_rdata;
                    state_nx  = ST_RESP;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Request latch, response data and memory address/data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (accept) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
            if (state == ST_LOOKUP) begin
                cpu_hit   <= hit;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                if (!req_we && hit) begin
                    cpu_rdata <= line_data;
                end
            end
            if ((state == ST_MEM_RD) && mem_ack) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    // Saturating hit/miss counters, sampled once per access in LOOKUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) begin
                hit_q <= sat_inc16(hit_q);
            end else begin
                miss_q <= sat_inc16(miss_q);
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - directed table-driven bench for dm_cache_ctrl
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_hit;
    logic [7:0]  cpu_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        flush_pre;
        logic        flush_mem;
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        int          dly;
        logic [7:0]  mdata;
        logic        exp_hit;
        logic [7:0]  exp_rdata;
        logic        exp_mem;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    dm_cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_hit   (cpu_hit),
        .cpu_rdata (cpu_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic access(input int id, input vec_t v);
        int          n;
        int          cyc;
        int          mw;
        logic        got_done;
        logic        saw_mem;
        logic        m_we;
        logic [10:0] m_addr;
        logic [7:0]  m_wdata;
        logic        r_hit;
        logic [7:0]  r_rdata;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        if (v.flush_pre) begin
            flush = 1'b1;
            #1;
            chk($sformatf("v%0d_flush_ready", id), {31'd0, cpu_ready}, 32'd0);
            @(negedge clk);
            flush = 1'b0;
        end
        n = 0;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req  = 1'b0;
        cyc      = 1;
        mw       = 0;
        got_done = 1'b0;
        saw_mem  = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        r_hit    = 1'b0;
        r_rdata  = '0;
        while (!got_done && cyc < 60) begin
            if (cpu_done) begin
                got_done = 1'b1;
                r_hit    = cpu_hit;
                r_rdata  = cpu_rdata;
            end else begin
                if (mem_req) begin
                    if (!saw_mem) begin
                        saw_mem = 1'b1;
                        m_we    = mem_we;
                        m_addr  = mem_addr;
                        m_wdata = mem_wdata;
                        if (v.flush_mem) flush = 1'b1;
                    end
                    mw++;
                    if (mw >= v.dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.mdata;
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0;
                flush   = 1'b0;
                cyc++;
            end
        end
        chk($sformatf("v%0d_done", id), {31'd0, got_done}, 32'd1);
        chk($sformatf("v%0d_hit", id), {31'd0, r_hit}, {31'd0, v.exp_hit});
        chk($sformatf("v%0d_rdata", id), {24'd0, r_rdata}, {24'd0, v.exp_rdata});
        chk($sformatf("v%0d_mem_seen", id), {31'd0, saw_mem}, {31'd0, v.exp_mem});
        if (v.exp_mem) begin
            chk($sformatf("v%0d_mem_we", id), {31'd0, m_we}, {31'd0, v.we});
            chk($sformatf("v%0d_mem_addr", id), {21'd0, m_addr}, {21'd0, v.addr});
            if (v.we) chk($sformatf("v%0d_mem_wdata", id), {24'd0, m_wdata}, {24'd0, v.wdata});
        end else begin
            chk($sformatf("v%0d_latency", id), cyc, 32'd2);
        end
    endtask

    initial begin
        int   n;
        int   exp_hits;
        int   exp_miss;
        logic saw_done;
        vec_t v;

        //            fpre fmem we  addr     wdata  dly mdata  hit rdata  mem
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 11'h012, 8'h00, 3, 8'hC3, 1'b0, 8'hC3, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 11'h012, 8'h00, 3, 8'h00, 1'b1, 8'hC3, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 11'h092, 8'h00, 2, 8'h9A, 1'b0, 8'h9A, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 11'h012, 8'h00, 1, 8'hC3, 1'b0, 8'hC3, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 11'h012, 8'h55, 2, 8'h00, 1'b1, 8'hC3, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 11'h012, 8'h00, 1, 8'h00, 1'b1, 8'h55, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 11'h0F4, 8'hAA, 1, 8'h00, 1'b0, 8'h55, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 11'h0F4, 8'h00, 2, 8'h77, 1'b0, 8'h77, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 11'h0F4, 8'h00, 1, 8'h00, 1'b1, 8'h77, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 11'h123, 8'h00, 1, 8'h11, 1'b0, 8'h11, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 11'h7FF, 8'h00, 1, 8'hFF, 1'b0, 8'hFF, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 11'h7FF, 8'h00, 1, 8'h00, 1'b1, 8'hFF, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 11'h012, 8'h00, 2, 8'h55, 1'b0, 8'h55, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 11'h0F4, 8'h00, 3, 8'h77, 1'b0, 8'h77, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 11'h0F4, 8'h00, 1, 8'h00, 1'b1, 8'h77, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 11'h012, 8'h00, 1, 8'h00, 1'b1, 8'h55, 1'b0};

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_done", {31'd0, cpu_done}, 32'd0);
        chk("rst_hit", {31'd0, cpu_hit}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);

        // Stray mem_ack while idle must be ignored.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_ignored", {31'd0, cpu_done}, 32'd0);

        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < NV; i++) begin
            access(i, tbl[i]);
            if (tbl[i].exp_hit) exp_hits++;
            else exp_miss++;
        end

`ifdef DM_CACHE_STATS_EN
        chk("stat_hit_cnt", {16'd0, hit_cnt}, exp_hits);
        chk("stat_miss_cnt", {16'd0, miss_cnt}, exp_miss);
`else
        chk("stat_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        chk("stat_miss_cnt", {16'd0, miss_cnt}, 32'd0);
`endif

        // Reset in the middle of a refill: abort, no completion, line stays invalid.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h092;
        n = 0;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_mem_req_up", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
        saw_done = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'h9A;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) begin
            if (cpu_done) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_done", {31'd0, saw_done}, 32'd0);

        v = '{1'b0, 1'b0, 1'b0, 11'h092, 8'h00, 2, 8'h9A, 1'b0, 8'h9A, 1'b1};
        access(100, v);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
